// File: rtl/fifo_rr_sched_pkg.sv
// fifo_rr_sched_pkg: state encoding, channel index type and round-robin search shared by fifo_rr_sched.
package fifo_rr_sched_pkg;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SERVE = 1'b1;
  localparam int CH_IDX_W = 2;
  typedef logic [CH_IDX_W-1:0] ch_idx_t;
  // Returns {found, idx}: first set req bit after ptr, wrapping modulo n (n <= 16).
  function automatic logic [4:0] rr_search(input logic [15:0] req, input logic [3:0] ptr, input int n);
    logic f;
    logic [3:0] i;
    int c;
    f = 1'b0;
    i = '0;
    for (int k = 1; k <= 16; k++) begin
      c = (int'(ptr) + k) % n;
      if (k <= n && !f && req[c[3:0]]) begin
        f = 1'b1;
        i = c[3:0];
      end
    end
    return {f, i};
  endfunction
endpackage

// File: rtl/fifo_rr_sched_rr_pick.sv
// rr_pick: combinational rotate-priority picker, first request after ptr wins.
module rr_pick
  import fifo_rr_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CHBIT = 2
) (
  input  logic [NCH-1:0]   req,
  input  logic [CHBIT-1:0] ptr,
  output logic [CHBIT-1:0] idx,
  output logic             found
);
  logic [4:0] r;
  assign r = rr_search(16'(req), 4'(ptr), NCH);
  assign found = r[4];
  assign idx = CHBIT'(r[3:0]);
endmodule

// File: rtl/fifo_rr_sched.sv
// fifo_rr_sched: round-robin burst drain of NCH queues into one registered stream.
// FIFO_RR_SCHED_FULLPRI_EN gives full queues (ch_len MSB) priority, lowest index first.
module fifo_rr_sched
  import fifo_rr_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CHBIT = 2,
  parameter int WIDTH = 8,
  parameter int ADDRBIT = 4,
  parameter int BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCH-1:0]             ch_en,
  input  logic [NCH-1:0]             ch_nemp,
  input  logic [NCH*WIDTH-1:0]       ch_dout,
  input  logic [NCH*(ADDRBIT+1)-1:0] ch_len,
  output logic [NCH-1:0]             ch_rd,
  output logic                       out_vld,
  output logic [WIDTH-1:0]           out_dat,
  output logic [CHBIT-1:0]           out_ch,
  input  logic                       out_rdy,
  output logic                       busy
);
  logic [0:0] state;
  logic [CHBIT-1:0] gnt, ptr, pick, arb_ptr;
  logic [ADDRBIT:0] bcnt;
  logic [NCH-1:0] elig, full, arb_req;
  logic found, take, pop, unused_len;
  assign elig = ch_en & ch_nemp;
`ifdef FIFO_RR_SCHED_FULLPRI_EN
  always_comb begin
    full = '0;
    for (int i = 0; i < NCH; i++) full[i] = ch_len[i*(ADDRBIT+1)+ADDRBIT] & elig[i];
  end
`else
  assign full = '0;
`endif
  assign unused_len = ^ch_len;
  // Full queues reuse the same picker with ptr=NCH-1 so the lowest index wins.
  assign arb_req = |full ? full : elig;
  assign arb_ptr = |full ? CHBIT'(NCH-1) : ptr;
  rr_pick #(.NCH(NCH), .CHBIT(CHBIT)) u_pick (
    .req(arb_req),
    .ptr(arb_ptr),
    .idx(pick),
    .found(found)
  );
  assign take = !out_vld || out_rdy;
  assign pop = state == SERVE && ch_nemp[gnt] && take;
  assign ch_rd = pop ? NCH'(1) << gnt : '0;
  assign busy = state == SERVE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      ptr <= CHBIT'(NCH-1);
      bcnt <= '0;
      out_vld <= 1'b0;
      out_dat <= '0;
      out_ch <= '0;
    end else begin
      if (state == IDLE) begin
        if (found) begin
          state <= SERVE;
          gnt <= pick;
          ptr <= pick;
          bcnt <= '0;
        end
      end else begin
        if (!ch_nemp[gnt] || (pop && bcnt == (ADDRBIT+1)'(BURST-1))) state <= IDLE;
        if (pop) bcnt <= bcnt + 1'b1;
      end
      if (pop) begin
        out_vld <= 1'b1;
        out_dat <= ch_dout[gnt*WIDTH +: WIDTH];
        out_ch <= gnt;
      end else if (out_rdy) out_vld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fifo_rr_sched.sv
// tb_fifo_rr_sched: scoreboard bench with queue models feeding fifo_rr_sched.
// Define FIFO_RR_SCHED_FULLPRI_EN to also exercise full-queue priority.
module tb_fifo_rr_sched;
  import fifo_rr_sched_pkg::*;
  logic clk = 0, rst = 1;
  logic [3:0] ch_en = '0, ch_nemp = '0, ch_rd;
  logic [31:0] ch_dout = '0;
  logic [19:0] ch_len = '0;
  logic out_vld, out_rdy = 1'b1, busy;
  logic [7:0] out_dat;
  ch_idx_t out_ch;
  logic [7:0] q [4][$];
  logic [9:0] exp_q [$];
  int n_vec = 0, n_err = 0;
  bit v1 [9] = '{0, 1, 1, 1, 1, 0, 1, 1, 0};
  bit b1 [9] = '{1, 1, 1, 1, 0, 1, 1, 1, 0};
  always #5 clk = ~clk;
  fifo_rr_sched dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .ch_nemp(ch_nemp), .ch_dout(ch_dout),
    .ch_len(ch_len), .ch_rd(ch_rd), .out_vld(out_vld), .out_dat(out_dat),
    .out_ch(out_ch), .out_rdy(out_rdy), .busy(busy)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] mk(int c, int s);
    return 8'((c << 6) | s);
  endfunction
  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      ch_nemp[i] = q[i].size() != 0;
      ch_dout[i*8 +: 8] = q[i].size() != 0 ? q[i][0] : 8'h00;
    end
  endtask
  task automatic clear();
    for (int i = 0; i < 4; i++) q[i].delete();
    exp_q.delete();
    refresh();
  endtask
  task automatic load(int c, int n, int s0, bit add_exp);
    for (int k = 0; k < n; k++) begin
      q[c].push_back(mk(c, s0 + k));
      if (add_exp) exp_q.push_back({2'(c), mk(c, s0 + k)});
    end
    refresh();
  endtask
  task automatic expect_words(int c, int s0, int n);
    for (int k = 0; k < n; k++) exp_q.push_back({2'(c), mk(c, s0 + k)});
  endtask
  task automatic step();
    logic [3:0] rd;
    logic [9:0] e;
    @(negedge clk);
    chk("rd_onehot", 32'($onehot0(ch_rd)), 1);
    if (out_vld && out_rdy) begin
      if (exp_q.size() == 0) chk("spurious", 32'(out_vld), 0);
      else begin
        e = exp_q.pop_front();
        chk("word", 32'({out_ch, out_dat}), 32'(e));
      end
    end
    rd = ch_rd;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (rd[i] && q[i].size() != 0) void'(q[i].pop_front());
    refresh();
  endtask
  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  task automatic drain(string tag, int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) step();
    chk(tag, exp_q.size(), 0);
    repeat (4) step();
  endtask
  initial begin
    @(posedge clk);
    #1;
    chk("rst_vld", 32'(out_vld), 0);
    chk("rst_dat", 32'(out_dat), 0);
    chk("rst_ch", 32'(out_ch), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd", 32'(ch_rd), 0);
    rst = 0;
    // single channel, 6 words: burst of 4, gap, 2 more, empty exit
    ch_en = 4'hf;
    out_rdy = 1;
    load(0, 6, 0, 1);
    for (int k = 0; k < 9; k++) begin
      step();
      chk("t1_vld", 32'(out_vld), 32'(v1[k]));
      chk("t1_busy", 32'(busy), 32'(b1[k]));
    end
    chk("t1_drain", exp_q.size(), 0);
    // all channels, 8 words each: two round-robin rounds of 4-word bursts
    do_reset();
    clear();
    for (int c = 0; c < 4; c++) load(c, 8, 0, 0);
    for (int r = 0; r < 2; r++) for (int c = 0; c < 4; c++) expect_words(c, r * 4, 4);
    drain("t2_drain", 120);
    // backpressure mid-burst
    do_reset();
    clear();
    load(2, 6, 0, 1);
    step();
    step();
    out_rdy = 0;
    #1;
    chk("t3_rd0", 32'(ch_rd), 0);
    repeat (3) begin
      step();
      chk("t3_vld", 32'(out_vld), 1);
      chk("t3_hold", 32'({out_ch, out_dat}), 32'({2'd2, mk(2, 0)}));
      chk("t3_rd", 32'(ch_rd), 0);
    end
    out_rdy = 1;
    step();
    chk("t3_busy1", 32'(busy), 1);
    step();
    chk("t3_busy2", 32'(busy), 1);
    step();
    chk("t3_bend", 32'(busy), 0);
    drain("t3_drain", 40);
    // enable mask 1010: channels 1 and 3 alternate
    do_reset();
    clear();
    ch_en = 4'b1010;
    for (int c = 0; c < 4; c++) load(c, 8, 0, 0);
    for (int r = 0; r < 2; r++) begin
      expect_words(1, r * 4, 4);
      expect_words(3, r * 4, 4);
    end
    drain("t4_drain", 100);
    chk("t4_q0", q[0].size(), 8);
    chk("t4_q2", q[2].size(), 8);
`ifdef FIFO_RR_SCHED_FULLPRI_EN
    // full ch3 beats round-robin ch1 with ptr=0
    do_reset();
    clear();
    ch_en = 4'hf;
    load(0, 1, 0, 1);
    drain("t5_pre", 20);
    ch_len[19] = 1'b1;
    load(3, 2, 0, 1);
    load(1, 2, 0, 1);
    drain("t5_drain", 40);
    ch_len = '0;
`endif
    // reset in the middle of a burst
    do_reset();
    clear();
    ch_en = 4'hf;
    load(2, 6, 0, 0);
    expect_words(2, 0, 1);
    repeat (3) step();
    chk("t6_pre", exp_q.size(), 0);
    #2;
    rst = 1;
    #1;
    chk("t6_vld", 32'(out_vld), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_rd", 32'(ch_rd), 0);
    step();
    chk("t6_nopop", q[2].size(), 4);
    rst = 0;
    load(1, 2, 0, 1);
    expect_words(2, 2, 4);
    drain("t6_drain", 60);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_rr_sched.md
# fifo_rr_sched

Round-robin read scheduler that drains NCH `fifodoutx`-style queues into one registered output stream. Each queue presents a registered head word with `notempty`, takes a one-cycle `fiford` pop, and reports its `fifolen`. The scheduler grants one queue at a time, pops up to BURST words from it, tags each word with its channel id, and honours downstream backpressure. It sits between per-channel ingress FIFOs and a shared single-port consumer such as a packer or bus writer.

## Interface
- NCH, 4: number of queues (2..16).
- CHBIT, 2: channel id width; 2^CHBIT >= NCH.
- WIDTH, 8: data width.
- ADDRBIT, 4: queue address bits; length fields are ADDRBIT+1 bits wide.
- BURST, 4: maximum pops per grant (1..2^ADDRBIT).
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous and active-high.
- ch_en  in  NCH  per-queue enable mask.
- ch_nemp  in  NCH  queue `notempty`; the head word is valid when this is high.
- ch_dout  in  NCH*WIDTH  queue head words; channel i occupies bits [i*WIDTH +: WIDTH].
- ch_len  in  NCH*(ADDRBIT+1)  queue `fifolen`; the MSB of each field means the queue is full.
- ch_rd  out  NCH  one-hot pop strobe, driven to the queues' `fiford`.
- out_vld  out  1  output word valid.
- out_dat  out  WIDTH  output word.
- out_ch  out  CHBIT  source channel of out_dat.
- out_rdy  in  1  consumer accepts the output word when out_vld & out_rdy.
- busy  out  1  high while in SERVE.

## Operation
- Eligibility: channel i is eligible when ch_en[i] & ch_nemp[i].
- The output stage is a single register. Define take = !out_vld | out_rdy.
- IDLE state:
  - If any channel is eligible, grant the first eligible channel searching from ptr+1 upward, modulo NCH.
  - Load gnt with that channel, set ptr = gnt, clear bcnt, and go to SERVE.
  - If no channel is eligible, stay in IDLE.
- SERVE state:
  - ch_rd[gnt] = ch_nemp[gnt] & take. This is combinational; no other ch_rd bit is ever high.
  - On each pop, load out_dat = ch_dout[gnt], out_ch = gnt, out_vld = 1, and increment bcnt.
  - If out_rdy is high and no pop occurs, clear out_vld.
- SERVE exits to IDLE when either condition holds:
  - Burst end: the pop cycle in which bcnt reaches BURST-1.
  - Empty: a cycle with ch_nemp[gnt] low.
- Clearing ch_en[gnt] during SERVE does not end the grant. It takes effect at the next arbitration.
- Backpressure (take low): no pop occurs and the output holds stable; bcnt does not advance.
- bcnt is ADDRBIT+1 bits wide and never exceeds BURST.
- ptr wraps from NCH-1 to 0.

## Timing
- Reset values:
  - out_vld=0, out_dat=0, out_ch=0, busy=0, ch_rd=0.
  - state=IDLE, gnt=0, bcnt=0.
  - ptr=NCH-1, so channel 0 wins the first arbitration.
- Latency:
  - A channel becoming eligible in IDLE is granted at the next edge.
  - Its first pop occurs in the following cycle.
  - Each word appears on out_* one cycle after its pop cycle.
- Throughput: one word per cycle during a burst when out_rdy is held high.
- Channel switch overhead:
  - After a burst end: 1 idle cycle (IDLE).
  - After an empty exit: 2 idle cycles (empty detection, then IDLE).
- Rising ch_nemp on a non-granted channel during SERVE has no effect until IDLE.
- Reset mid-burst: all state returns to reset values immediately. The word in the output stage is lost; the queues are not popped.

## Configuration
- FIFO_RR_SCHED_FULLPRI_EN defined:
  - In IDLE, any eligible channel whose ch_len MSB is set wins over round-robin; the lowest index wins among such channels.
  - ptr is still set to the granted channel.
- FIFO_RR_SCHED_FULLPRI_EN undefined: ch_len is ignored and arbitration is pure round-robin. The port remains present either way.

## Structure
- Shared package holds:
  - the state encoding (IDLE=1'b0, SERVE=1'b1);
  - a `ch_idx_t` typedef of width CHBIT;
  - the round-robin search function.
- One sub-module: `rr_pick`, a combinational rotate-priority picker taking (req, ptr) and returning (idx, found). It is shared by the normal and full-priority paths.

## Test plan
- Reset, then only ch0 non-empty with 6 words, out_rdy=1:
  - ch0 is granted one cycle later.
  - Words 0-3 appear on consecutive cycles with out_ch=0.
  - A 1-cycle gap follows, then words 4-5.
  - After the empty exit, busy drops.
- All 4 channels hold 8 words each, out_rdy=1:
  - Grant order is 0,1,2,3,0,1,2,3.
  - Each grant yields exactly 4 words.
  - 32 words are delivered in total, with none lost or duplicated.
- Backpressure: hold out_rdy=0 for 3 cycles mid-burst.
  - out_vld/out_dat/out_ch stay stable and ch_rd stays 0.
  - bcnt is unchanged.
  - The burst resumes afterwards with no word loss.
- ch_en=4'b1010 with all channels non-empty: only channels 1 and 3 are granted, alternating.
- With FIFO_RR_SCHED_FULLPRI_EN defined, ptr=0, and ch_len[3] MSB set while ch1 and ch3 are eligible: ch3 is granted first.
- Assert rst during a burst: out_vld goes to 0 asynchronously, and the next grant goes to the lowest eligible channel (ptr=NCH-1).
